// File: rtl/io_scan_controller.sv
// Periodic/software-triggered I/O scanner: reads every port into a shadow and commits it
// atomically to the input image, then writes the output-image snapshot back to the ports.
module io_scan_controller #(
   parameter int BITS        = 16,
   parameter int NPORTS      = 5,
   parameter int SCAN_PERIOD = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scan_start,
   input  logic [NPORTS-1:0] out_mask,
   output logic              scan_busy,
   output logic              scan_done,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [3:0]        cpu_addr,
   input  logic [BITS-1:0]   cpu_wdata,
   output logic [BITS-1:0]   cpu_rdata,
   output logic              cpu_ack,
   output logic              io_en,
   output logic              io_r_or_w,
   output logic [3:0]        io_addr,
   output logic [BITS-1:0]   io_wdata,
   input  logic [BITS-1:0]   io_rdata
);

   localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam logic [IW-1:0] LAST = IW'(NPORTS - 1);
   localparam logic [TW-1:0] TMAX = TW'((SCAN_PERIOD > 0) ? SCAN_PERIOD - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            pend_q, pend_d;
   logic [TW-1:0]   tmr_q;
   logic            timer_hit;
   logic            trig_now;
   logic [BITS-1:0] rd_val;
   logic [BITS-1:0] rd_mux;
   logic            ack_q;
   logic [BITS-1:0] rdata_q;

   logic [BITS-1:0] ishd_q [NPORTS];
   logic [BITS-1:0] iimg_q [NPORTS];
   logic [BITS-1:0] oimg_q [NPORTS];
   logic [BITS-1:0] snap_q [NPORTS];

   // Free-running period timer; fires independently of the scan FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q <= '0;
      end else if (SCAN_PERIOD > 0) begin
         tmr_q <= (tmr_q == TMAX) ? '0 : tmr_q + 1'b1;
      end
   end

   assign timer_hit = (SCAN_PERIOD > 0) && (tmr_q == TMAX);
   assign trig_now  = scan_start | timer_hit;

   // Port 0 is analog (full word); digital ports keep only their level bit.
   assign rd_val = (idx_q == '0) ? io_rdata : {{(BITS-1){1'b0}}, io_rdata[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pend_d    = pend_q | trig_now;
      io_en     = 1'b0;
      io_r_or_w = 1'b0;
      io_addr   = '0;
      io_wdata  = '0;
      scan_busy = 1'b0;
      scan_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trig_now || pend_q) begin
               state_d = S_READ;
               idx_d   = '0;
               pend_d  = 1'b0;
            end
         end
         S_READ: begin
            io_en     = 1'b1;
            io_addr   = 4'(idx_q);
            scan_busy = 1'b1;
            if (idx_q == LAST) begin
               state_d = S_WRITE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_WRITE: begin
            io_en     = out_mask[idx_q];
            io_r_or_w = 1'b1;
            io_addr   = 4'(idx_q);
            io_wdata  = snap_q[idx_q];
            scan_busy = 1'b1;
            if (idx_q == LAST) begin
               state_d = S_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            scan_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The last READ edge commits the whole input image and freezes the output snapshot.
   for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ishd_q[gi] <= '0;
            iimg_q[gi] <= '0;
            oimg_q[gi] <= '0;
            snap_q[gi] <= '0;
         end else begin
            if (state_q == S_READ && idx_q == IW'(gi)) begin
               ishd_q[gi] <= rd_val;
            end
            if (state_q == S_READ && idx_q == LAST) begin
               iimg_q[gi] <= (gi == NPORTS - 1) ? rd_val : ishd_q[gi];
               snap_q[gi] <= oimg_q[gi];
            end
            if (cpu_req && cpu_we && cpu_addr == 4'(gi)) begin
               oimg_q[gi] <= cpu_wdata;
            end
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (cpu_addr == 4'(i)) rd_mux = iimg_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= cpu_req;
         rdata_q <= (cpu_req && !cpu_we) ? rd_mux : '0;
      end
   end

   assign cpu_ack   = ack_q;
   assign cpu_rdata = rdata_q;

endmodule
